// File: rtl/mux2_arb_pkg.sv
// ============================================================================
// Module  : mux2_arb_pkg
// Brief   : Shared types and constants for the two-requester round-robin arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mux2_arb_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int STAT_W        = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/bit8_2to1mux.sv
// ============================================================================
// Module  : bit8_2to1mux
// Brief   : 8-bit 2:1 multiplexer; sel=0 passes in1, sel=1 passes in2.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bit8_2to1mux (
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic       sel,
    output logic [7:0] out
);

    assign out = sel ? in2 : in1;

endmodule

`default_nettype wire

// File: rtl/mux2_rr_arbiter.sv
// ============================================================================
// Module  : mux2_rr_arbiter
// Brief   : Round-robin, burst-limited arbiter sharing one output register
//           between two valid/ready requesters. Optional per-requester grant
//           counters are enabled with MUX2_ARB_STATS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mux2_rr_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    input  logic [WIDTH-1:0]   req0_data,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [WIDTH-1:0]   req1_data,
    output logic               req1_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    input  logic               out_ready,
    output logic               sel,
`ifdef MUX2_ARB_STATS_EN
    output logic               busy,
    output logic [STAT_W-1:0]  gnt0_cnt,
    output logic [STAT_W-1:0]  gnt1_cnt
`else
    output logic               busy
`endif
);

    localparam int              CNT_W      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              sel_q, sel_d;
    logic              busy_q;
    logic              out_valid_q;
    logic [WIDTH-1:0]  out_data_q;

    logic              w_space;
    logic              w_gnt1;
    logic              w_cur_valid;
    logic              w_oth_valid;
    logic              w_xfer;
    arb_state_e        w_other;
    logic [WIDTH-1:0]  w_mux_out;

    assign w_space     = !out_valid_q || out_ready;
    assign w_gnt1      = (state_q == GRANT1);
    assign w_cur_valid = w_gnt1 ? req1_valid : req0_valid;
    assign w_oth_valid = w_gnt1 ? req0_valid : req1_valid;
    assign w_other     = w_gnt1 ? GRANT0 : GRANT1;
    assign w_xfer      = (state_q != IDLE) && w_cur_valid && w_space;

    assign req0_ready  = (state_q == GRANT0) && w_space;
    assign req1_ready  = (state_q == GRANT1) && w_space;

    generate
        if (WIDTH == 8) begin : g_mux8
            bit8_2to1mux u_mux (
                .in1 (req0_data),
                .in2 (req1_data),
                .sel (sel_q),
                .out (w_mux_out)
            );
        end else begin : g_mux_generic
            assign w_mux_out = sel_q ? req1_data : req0_data;
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        burst_cnt_d  = burst_cnt_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (req0_valid && req1_valid)
                    state_d = last_grant_q ? GRANT0 : GRANT1;
                else if (req0_valid)
                    state_d = GRANT0;
                else if (req1_valid)
                    state_d = GRANT1;
            end
            GRANT0, GRANT1: begin
                // Counter saturates at the limit; the switch only fires if the peer is waiting.
                if (w_xfer) begin
                    last_grant_d = w_gnt1;
                    if (burst_cnt_q != BURST_LAST)
                        burst_cnt_d = burst_cnt_q + 1'b1;
                end
                if (w_xfer && (burst_cnt_q == BURST_LAST) && w_oth_valid) begin
                    state_d     = w_other;
                    burst_cnt_d = '0;
                end else if (!w_cur_valid) begin
                    state_d     = w_oth_valid ? w_other : IDLE;
                    burst_cnt_d = '0;
                end
            end
            default: begin
                state_d     = IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    // Idle keeps the previous select so the mux does not toggle between bursts.
    always_comb begin
        case (state_d)
            GRANT0:  sel_d = 1'b0;
            GRANT1:  sel_d = 1'b1;
            default: sel_d = (state_q == IDLE) ? sel_q : last_grant_d;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            burst_cnt_q  <= '0;
            last_grant_q <= 1'b1;
            sel_q        <= 1'b0;
            busy_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            burst_cnt_q  <= burst_cnt_d;
            last_grant_q <= last_grant_d;
            sel_q        <= sel_d;
            busy_q       <= (state_d != IDLE);
            if (w_xfer) begin
                out_valid_q <= 1'b1;
                out_data_q  <= w_mux_out;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sel       = sel_q;
    assign busy      = busy_q;

`ifdef MUX2_ARB_STATS_EN
    logic [STAT_W-1:0] gnt0_cnt_q;
    logic [STAT_W-1:0] gnt1_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt0_cnt_q <= '0;
            gnt1_cnt_q <= '0;
        end else begin
            if (w_xfer && !w_gnt1 && (gnt0_cnt_q != {STAT_W{1'b1}}))
                gnt0_cnt_q <= gnt0_cnt_q + 1'b1;
            if (w_xfer && w_gnt1 && (gnt1_cnt_q != {STAT_W{1'b1}}))
                gnt1_cnt_q <= gnt1_cnt_q + 1'b1;
        end
    end

    assign gnt0_cnt = gnt0_cnt_q;
    assign gnt1_cnt = gnt1_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux2_rr_arbiter.sv
// ============================================================================
// Module  : tb_mux2_rr_arbiter
// Brief   : Scoreboard bench for mux2_rr_arbiter (covers MUX2_ARB_STATS_EN too).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mux2_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid, out_ready;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready, out_valid, sel, busy;
    logic [7:0] out_data;
`ifdef MUX2_ARB_STATS_EN
    logic [15:0] gnt0_cnt, gnt1_cnt;
`endif

    always #5 clk = ~clk;

    mux2_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .sel        (sel),
`ifdef MUX2_ARB_STATS_EN
        .busy       (busy),
        .gnt0_cnt   (gnt0_cnt),
        .gnt1_cnt   (gnt1_cnt)
`else
        .busy       (busy)
`endif
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] src0[$];
    logic [7:0] src1[$];
    logic [7:0] exp_q[$];
    int         acc_log[$];
    logic       acc0, acc1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Observe handshakes on the falling edge, away from the active edge.
    task automatic sample();
        @(negedge clk);
        acc0 = req0_valid & req0_ready;
        acc1 = req1_valid & req1_ready;
        if (acc0) begin
            check_val("sel_on_acc0", {31'd0, sel}, 32'd0);
            acc_log.push_back(0);
        end
        if (acc1) begin
            check_val("sel_on_acc1", {31'd0, sel}, 32'd1);
            acc_log.push_back(1);
        end
        if (out_valid && out_ready) begin
            check_val("word_expected", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0)
                check_val("out_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        if (acc0) begin
            void'(src0.pop_front());
            if (src0.size() > 0) req0_data = src0[0];
            else                 req0_valid = 1'b0;
        end
        if (acc1) begin
            void'(src1.pop_front());
            if (src1.size() > 0) req1_data = src1[0];
            else                 req1_valid = 1'b0;
        end
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    task automatic load();
        req0_valid = (src0.size() > 0);
        req1_valid = (src1.size() > 0);
        if (src0.size() > 0) req0_data = src0[0];
        if (src1.size() > 0) req1_data = src1[0];
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        out_ready  = 1'b1;
        acc0       = 1'b0;
        acc1       = 1'b0;
        src0.delete();
        src1.delete();
        exp_q.delete();
        acc_log.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while ((src0.size() + src1.size() + exp_q.size()) > 0 && n < max_cyc) begin
            cycle();
            n++;
        end
        check_val("drain_done", src0.size() + src1.size() + exp_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b0;
        req0_data = 8'h00; req1_data = 8'h00;
        do_reset();

        check_val("rst_out_valid",  {31'd0, out_valid},  32'd0);
        check_val("rst_out_data",   {24'd0, out_data},   32'd0);
        check_val("rst_sel",        {31'd0, sel},        32'd0);
        check_val("rst_busy",       {31'd0, busy},       32'd0);
        check_val("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        check_val("rst_req1_ready", {31'd0, req1_ready}, 32'd0);

        // Single requester: one-cycle bubble, then grant, then data.
        src0.push_back(8'hAA); exp_q.push_back(8'hAA);
        load();
        check_val("t1_bubble_ready", {31'd0, req0_ready}, 32'd0);
        cycle();
        check_val("t1_busy",  {31'd0, busy},       32'd1);
        check_val("t1_sel",   {31'd0, sel},        32'd0);
        check_val("t1_ready", {31'd0, req0_ready}, 32'd1);
        cycle();
        check_val("t1_out_valid", {31'd0, out_valid}, 32'd1);
        cycle();
        check_val("t1_drained",   exp_q.size(), 32'd0);
        check_val("t1_idle_busy", {31'd0, busy}, 32'd0);
        check_val("t1_idle_ov",   {31'd0, out_valid}, 32'd0);

        // Tie after reset goes to req0.
        do_reset();
        src0.push_back(8'h11); src1.push_back(8'h22);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        load();
        drain(20);
        check_val("t2_n_acc", acc_log.size(), 32'd2);
        if (acc_log.size() == 2) begin
            check_val("t2_first",  acc_log[0], 32'd0);
            check_val("t2_second", acc_log[1], 32'd1);
        end

        // Continuous contention: bursts of 4 alternate with no bubble.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            src0.push_back(8'(8'h10 + k));
            src1.push_back(8'(8'h80 + k));
        end
        for (int b = 0; b < 4; b++)
            for (int j = 0; j < 4; j++)
                exp_q.push_back((b % 2 == 0) ? 8'(8'h10 + (b / 2) * 4 + j) : 8'(8'h80 + (b / 2) * 4 + j));
        load();
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 100) begin
            cycle();
            cyc++;
        end
        check_val("t3_cycles", cyc, 32'd18);
        check_val("t3_n_acc", acc_log.size(), 32'd16);
        for (int k = 0; k < 16 && k < acc_log.size(); k++)
            check_val("t3_grant_order", acc_log[k], (k / 4) % 2);

        // Backpressure: nothing accepted while output is stalled.
        do_reset();
        out_ready = 1'b0;
        src0.push_back(8'h31); src0.push_back(8'h32); src0.push_back(8'h33);
        exp_q.push_back(8'h31); exp_q.push_back(8'h32); exp_q.push_back(8'h33);
        load();
        cycle();
        cycle();
        for (int i = 0; i < 5; i++) begin
            check_val("t4_req0_ready", {31'd0, req0_ready}, 32'd0);
            check_val("t4_req1_ready", {31'd0, req1_ready}, 32'd0);
            check_val("t4_out_valid",  {31'd0, out_valid},  32'd1);
            check_val("t4_out_hold",   {24'd0, out_data},   32'h31);
            cycle();
        end
        out_ready = 1'b1;
        drain(20);

        // Reset in the middle of a GRANT1 with a stalled word.
        do_reset();
        out_ready = 1'b0;
        src1.push_back(8'h51); src1.push_back(8'h52);
        load();
        cycle();
        cycle();
        check_val("t5_pre_sel",  {31'd0, sel},       32'd1);
        check_val("t5_pre_busy", {31'd0, busy},      32'd1);
        check_val("t5_pre_ov",   {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("t5_ov",     {31'd0, out_valid},  32'd0);
        check_val("t5_sel",    {31'd0, sel},        32'd0);
        check_val("t5_busy",   {31'd0, busy},       32'd0);
        check_val("t5_ready1", {31'd0, req1_ready}, 32'd0);

`ifdef MUX2_ARB_STATS_EN
        do_reset();
        for (int k = 0; k < 3; k++) begin src0.push_back(8'(8'h60 + k)); exp_q.push_back(8'(8'h60 + k)); end
        for (int k = 0; k < 5; k++) begin src1.push_back(8'(8'h70 + k)); exp_q.push_back(8'(8'h70 + k)); end
        load();
        drain(40);
        check_val("t6_gnt0", {16'd0, gnt0_cnt}, 32'd3);
        check_val("t6_gnt1", {16'd0, gnt1_cnt}, 32'd5);
        force dut.gnt0_cnt_q = 16'hFFFF;
        #1;
        release dut.gnt0_cnt_q;
        src0.push_back(8'h99); exp_q.push_back(8'h99);
        load();
        drain(20);
        check_val("t6_gnt0_sat", {16'd0, gnt0_cnt}, 32'h0000FFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
